// File: rtl/image_stream_pkg.sv
// Shared definitions for the image stream source.
//   - state_t       : source FSM encoding (idle / streaming)
//   - COORD_W       : width of the raster counters and the xpos/ypos outputs
//   - COORD_LIMIT   : largest H/V total the counters can represent
//   - raster_total  : active + front porch + sync + back porch, used for both axes
package image_stream_pkg;

  localparam int COORD_W     = 11;
  localparam int COORD_LIMIT = 2 ** COORD_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int raster_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/image_stream_source_timing.sv
// video_timing_gen: raster counters and stage-0 timing decode.
// Ports:
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   run          : counters advance while high, are held at 0 while low
//   h_cnt, v_cnt : current raster position
//   act          : position is inside the active window (and running)
//   hs, vs       : position is inside the horizontal / vertical sync pulse
//   frame_last   : last cycle of the frame (h = H_TOTAL-1, v = V_TOTAL-1)
module video_timing_gen
  import image_stream_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [COORD_W-1:0] h_cnt,
  output logic [COORD_W-1:0] v_cnt,
  output logic               act,
  output logic               hs,
  output logic               vs,
  output logic               frame_last
);

  localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_total_check
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [COORD_W-1:0] h_cnt_reg;
  logic [COORD_W-1:0] v_cnt_reg;
  logic               h_wrap;
  logic               v_wrap;

  assign h_wrap = (h_cnt_reg == H_LAST);
  assign v_wrap = (v_cnt_reg == V_LAST);

  // The last frame cycle wraps both counters to 0, so leaving RUN there
  // already lands on (0,0); the !run branch only matters after a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (!run) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_wrap ? '0 : h_cnt_reg + 1'b1;
      if (h_wrap) begin
        v_cnt_reg <= v_wrap ? '0 : v_cnt_reg + 1'b1;
      end
    end
  end

  assign h_cnt      = h_cnt_reg;
  assign v_cnt      = v_cnt_reg;
  assign act        = run && (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
  assign hs         = run && (h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST);
  assign vs         = run && (v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST);
  assign frame_last = run && h_wrap && v_wrap;

endmodule

// File: rtl/image_stream_source.sv
// image_stream_source: raster frame source reading RGB565 pixels from a
// synchronous frame memory (1-clock read latency).
// Ports:
//   clk, rst_n            : pixel clock, asynchronous active-low reset
//   start, cont, stop     : begin request (cont sampled with it), stop at frame end
//   busy                  : streaming
//   frame_done            : pulse with the last active pixel on the output
//   rd_en, rd_addr        : memory read strobe and linear pixel address
//   rd_data               : memory data, valid one clock after rd_en
//   post_frame_vsync/hsync/de, post_rgb, xpos, ypos : output stream, 2 clocks
//                           behind the raster counters; data/coords 0 outside de
module image_stream_source
  import image_stream_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cont,
  input  logic               stop,
  output logic               busy,
  output logic               frame_done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [15:0]        rd_data,
  output logic               post_frame_vsync,
  output logic               post_frame_hsync,
  output logic               post_frame_de,
  output logic [15:0]        post_rgb,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos
);

  if (H_ACTIVE * V_ACTIVE > 2 ** ADDR_W) begin : g_addr_check
    $error("image_stream_source: ADDR_W too small for one frame");
  end

  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_ACTIVE - 1);

  state_t             state_reg;
  logic               cont_latched_reg;
  logic               stop_latched_reg;
  logic               busy_reg;
  logic               run;

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               act;
  logic               hs;
  logic               vs;
  logic               frame_last;

  assign run = (state_reg == ST_RUN);

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .act        (act),
    .hs         (hs),
    .vs         (vs),
    .frame_last (frame_last)
  );

  // Source FSM. A stop pulse seen on the frame's last cycle counts just like
  // one latched earlier in the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      cont_latched_reg <= 1'b0;
      stop_latched_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          stop_latched_reg <= 1'b0;
          if (start) begin
            cont_latched_reg <= cont;
            state_reg        <= ST_RUN;
            busy_reg         <= 1'b1;
          end
        end
        ST_RUN: begin
          if (frame_last) begin
            if (!cont_latched_reg || stop_latched_reg || stop) begin
              state_reg        <= ST_IDLE;
              busy_reg         <= 1'b0;
              stop_latched_reg <= 1'b0;
            end
          end else if (stop) begin
            stop_latched_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Linear read address. It rolls back to 0 right after the last active
  // pixel so the register never holds a value outside the frame.
  logic [ADDR_W-1:0] addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
    end else if (!run || frame_last) begin
      addr_reg <= '0;
    end else if (act) begin
      addr_reg <= (addr_reg == ADDR_LAST) ? '0 : addr_reg + 1'b1;
    end
  end

  // Stage 1 lines timing up with the memory read latency; stage 2 captures
  // rd_data together with the delayed timing.
  logic               act_s1_reg, hs_s1_reg, vs_s1_reg;
  logic [COORD_W-1:0] h_s1_reg, v_s1_reg;
  logic               de_reg, hsync_reg, vsync_reg, frame_done_reg;
  logic [COORD_W-1:0] xpos_reg, ypos_reg;
  logic [15:0]        rgb_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_s1_reg     <= 1'b0;
      hs_s1_reg      <= 1'b0;
      vs_s1_reg      <= 1'b0;
      h_s1_reg       <= '0;
      v_s1_reg       <= '0;
      de_reg         <= 1'b0;
      hsync_reg      <= 1'b0;
      vsync_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      xpos_reg       <= '0;
      ypos_reg       <= '0;
      rgb_reg        <= '0;
    end else begin
      act_s1_reg     <= act;
      hs_s1_reg      <= hs;
      vs_s1_reg      <= vs;
      h_s1_reg       <= h_cnt;
      v_s1_reg       <= v_cnt;
      de_reg         <= act_s1_reg;
      hsync_reg      <= hs_s1_reg;
      vsync_reg      <= vs_s1_reg;
      frame_done_reg <= act_s1_reg && (h_s1_reg == X_LAST) && (v_s1_reg == Y_LAST);
      xpos_reg       <= act_s1_reg ? h_s1_reg : '0;
      ypos_reg       <= act_s1_reg ? v_s1_reg : '0;
      rgb_reg        <= act_s1_reg ? rd_data : '0;
    end
  end

  assign busy             = busy_reg;
  assign rd_en            = act;
  assign rd_addr          = addr_reg;
  assign frame_done       = frame_done_reg;
  assign post_frame_de    = de_reg;
  assign post_frame_hsync = hsync_reg;
  assign post_frame_vsync = vsync_reg;
  assign post_rgb         = rgb_reg;
  assign xpos             = xpos_reg;
  assign ypos             = ypos_reg;

endmodule
